apb_cmd_sequencer: RTL and testbench

- Upstream command stage for the APB protocol block (bridge plus GPIO/UART slaves).
- Accepts buffered read/write commands over a valid/ready interface, sequences each into an APB SETUP/ACCESS transfer on the protocol block's bench-side inputs, and waits for completion.
- Returns read data and error status over a response handshake.
- Serialises accesses so that software or test drivers never toggle pwrite/penable/transfer by hand.

---
 rtl/apb_cmd_sequencer.sv | 169 ++++++++++++++++
 tb/tb_apb_cmd_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer: queues read/write commands and turns each one into a single
// APB SETUP/ACCESS transfer on the protocol block, returning data and error status.
module apb_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        pclk,
    input  logic        PRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_sel,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        transfer,
    output logic        pwrite,
    output logic        penable,
    output logic [1:0]  Psel,
    output logic [4:0]  write_paddr,
    output logic [4:0]  apb_read_paddr,
    output logic [31:0] write_data,
    input  logic        pready,
    input  logic [31:0] apb_read_data_out,
    input  logic        PSLVERR,
    input  logic [2:0]  Error_Identify,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [2:0]  rsp_err_code
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    // One extra bit so a TIMEOUT of 1 still gets a 1-bit counter.
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic        write;
        logic [1:0]  sel;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             push;
    logic             pop;
    cmd_t             head;

    assign cmd_ready = (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign head      = fifo_mem[rd_ptr];

    // Command storage; contents need no reset since count gates every read.
    always_ff @(posedge pclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{write: cmd_write, sel: cmd_sel, addr: cmd_addr,
                                  wdata: cmd_wdata};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge pclk or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Transfer sequencer with registered bus and response outputs.
    always_ff @(posedge pclk or negedge PRESETn) begin
        if (!PRESETn) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            transfer       <= 1'b0;
            pwrite         <= 1'b0;
            penable        <= 1'b0;
            Psel           <= 2'b00;
            write_paddr    <= '0;
            apb_read_paddr <= '0;
            write_data     <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            rsp_err_code   <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head.sel == 2'd1 || head.sel == 2'd2) begin
                            // Loading the bus here makes the next cycle the SETUP phase.
                            transfer <= 1'b1;
                            penable  <= 1'b0;
                            Psel     <= head.sel;
                            pwrite   <= head.write;
                            if (head.write) begin
                                write_paddr <= head.addr;
                                write_data  <= head.wdata;
                            end else begin
                                apb_read_paddr <= head.addr;
                            end
                            state <= SETUP;
                        end else begin
                            // Bad select: answer with an error and never touch the bus.
                            rsp_valid    <= 1'b1;
                            rsp_err      <= 1'b1;
                            rsp_err_code <= 3'b110;
                            rsp_rdata    <= '0;
                            state        <= RESP;
                        end
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_rdata    <= pwrite ? 32'h0 : apb_read_data_out;
                        rsp_err      <= PSLVERR;
                        rsp_err_code <= PSLVERR ? Error_Identify : 3'b000;
                        transfer     <= 1'b0;
                        penable      <= 1'b0;
                        Psel         <= 2'b00;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_rdata    <= '0;
                        rsp_err      <= 1'b1;
                        rsp_err_code <= 3'b111;
                        transfer     <= 1'b0;
                        penable      <= 1'b0;
                        Psel         <= 2'b00;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// tb_apb_cmd_sequencer: directed scenarios plus randomized command batches checked
// against a transaction-level model of the sequencer.
module tb_apb_cmd_sequencer;
    localparam int T = 16;

    typedef struct {
        logic        wr;
        logic [1:0]  sel;
        logic [4:0]  addr;
        logic [31:0] wdata;
        int          w;     // ACCESS cycles of pready=0 before the slave answers
        logic        err;
        logic [2:0]  eid;
        logic [31:0] rd;
        int          rdly;  // cycles the response is held before rsp_ready
    } tcmd_t;

    logic        pclk = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_sel;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        transfer, pwrite, penable;
    logic [1:0]  Psel;
    logic [4:0]  write_paddr, apb_read_paddr;
    logic [31:0] write_data;
    logic        pready;
    logic [31:0] apb_read_data_out;
    logic        PSLVERR;
    logic [2:0]  Error_Identify;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  rsp_err_code;

    logic        echo_mode;
    logic [31:0] rd_drv;
    int          test_cnt = 0;
    int          fail_cnt = 0;

    // Echo mode makes the slave return a value tagged with the read address.
    assign apb_read_data_out = echo_mode ? (32'hEC00_0000 | {27'd0, apb_read_paddr}) : rd_drv;

    always #5 pclk = ~pclk;

    apb_cmd_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(T)) dut (
        .pclk(pclk), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .transfer(transfer), .pwrite(pwrite), .penable(penable), .Psel(Psel),
        .write_paddr(write_paddr), .apb_read_paddr(apb_read_paddr), .write_data(write_data),
        .pready(pready), .apb_read_data_out(apb_read_data_out), .PSLVERR(PSLVERR),
        .Error_Identify(Error_Identify),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_err_code(rsp_err_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic tcmd_t mk(input logic wr, input logic [1:0] sel, input logic [4:0] addr,
                                 input logic [31:0] wdata, input int w, input logic err,
                                 input logic [2:0] eid, input logic [31:0] rd);
        tcmd_t c;
        c.wr = wr; c.sel = sel; c.addr = addr; c.wdata = wdata; c.w = w;
        c.err = err; c.eid = eid; c.rd = rd; c.rdly = 0;
        return c;
    endfunction

    function automatic tcmd_t rand_cmd();
        tcmd_t c;
        c.wr    = 1'($urandom_range(0, 1));
        c.sel   = 2'($urandom_range(0, 3));
        c.addr  = 5'($urandom);
        c.wdata = $urandom;
        c.w     = ($urandom_range(0, 6) == 0) ? T + int'($urandom_range(0, 2))
                                              : int'($urandom_range(0, 5));
        c.err   = ($urandom_range(0, 3) == 0);
        c.eid   = 3'($urandom);
        c.rd    = $urandom;
        c.rdly  = int'($urandom_range(0, 2));
        return c;
    endfunction

    // Offer one command from a negedge; returns on the negedge after acceptance.
    task automatic push_cmd(input tcmd_t c);
        bit done = 0;
        cmd_valid = 1'b1; cmd_write = c.wr; cmd_sel = c.sel;
        cmd_addr = c.addr; cmd_wdata = c.wdata;
        for (int i = 0; i < 600 && !done; i++) begin
            done = cmd_ready;
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
        check("push_accepted", 32'(done), 1);
    endtask

    // Play the slave for one command and check the bus and the response it yields.
    task automatic serve(input tcmd_t c);
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [2:0]  exp_code;
        int          len;
        bit          seen = 0;
        bit          bus_seen = 0;
        if (c.sel == 2'd1 || c.sel == 2'd2) begin
            for (int i = 0; i < 60 && !seen; i++) begin
                @(negedge pclk);
                seen = transfer && !penable;
            end
            check("setup_seen", 32'(seen), 1);
            if (!seen) return;
            check("setup_psel", 32'(Psel), 32'(c.sel));
            check("setup_pwrite", 32'(pwrite), 32'(c.wr));
            if (c.wr) begin
                check("setup_waddr", 32'(write_paddr), 32'(c.addr));
                check("setup_wdata", write_data, c.wdata);
            end else begin
                check("setup_raddr", 32'(apb_read_paddr), 32'(c.addr));
            end
            len = (c.w < T) ? c.w + 1 : T;
            for (int n = 0; n < len; n++) begin
                @(negedge pclk);
                check("access_phase", 32'({transfer, penable, Psel}), 32'({2'b11, c.sel}));
                if (n == c.w) begin
                    pready = 1'b1; PSLVERR = c.err; Error_Identify = c.eid; rd_drv = c.rd;
                end
            end
            @(negedge pclk);
            pready = 1'b0; PSLVERR = 1'b0; Error_Identify = 3'b000; rd_drv = $urandom;
            check("resp_bus_idle", 32'({transfer, penable, Psel}), 0);
            if (c.w < T) begin
                exp_rdata = c.wr ? 32'h0 : c.rd;
                exp_err   = c.err;
                exp_code  = c.err ? c.eid : 3'b000;
            end else begin
                exp_rdata = 32'h0; exp_err = 1'b1; exp_code = 3'b111;
            end
        end else begin
            for (int i = 0; i < 60 && !seen; i++) begin
                @(negedge pclk);
                if (transfer) bus_seen = 1;
                seen = rsp_valid;
            end
            check("invalid_no_transfer", 32'(bus_seen), 0);
            exp_rdata = 32'h0; exp_err = 1'b1; exp_code = 3'b110;
        end
        check("rsp_valid", 32'(rsp_valid), 1);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", 32'({rsp_err, rsp_err_code}), 32'({exp_err, exp_code}));
        for (int i = 0; i < c.rdly; i++) begin
            @(negedge pclk);
            check("rsp_hold", 32'({rsp_valid, rsp_err, rsp_err_code}), 32'({1'b1, exp_err, exp_code}));
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", test_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        tcmd_t batch[$];
        int    k;
        int    acc;
        bit    seen;

        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sel = 2'b00;
        cmd_addr = '0; cmd_wdata = '0; pready = 1'b0; PSLVERR = 1'b0;
        Error_Identify = 3'b000; rsp_ready = 1'b0; echo_mode = 1'b0; rd_drv = '0;

        // Reset state.
        repeat (2) @(negedge pclk);
        check("reset_ctrl", 32'({transfer, pwrite, penable, Psel, rsp_valid, rsp_err, rsp_err_code}), 0);
        check("reset_addr", 32'({write_paddr, apb_read_paddr}), 0);
        check("reset_wdata", write_data, 0);
        check("reset_rdata", rsp_rdata, 0);
        check("reset_cmd_ready", 32'(cmd_ready), 1);
        PRESETn = 1'b1;
        repeat (2) @(negedge pclk);

        // GPIO write with first-cycle pready: cycle-exact latency.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = 2'd1;
        cmd_addr = 5'h04; cmd_wdata = 32'hA5A5_0001;
        check("lat_ready_t", 32'(cmd_ready), 1);
        @(negedge pclk);
        cmd_valid = 1'b0;
        check("lat_idle_t1", 32'(transfer), 0);
        @(negedge pclk);
        check("lat_setup_t2", 32'({transfer, penable, Psel, pwrite}), 32'({1'b1, 1'b0, 2'd1, 1'b1}));
        check("lat_waddr", 32'(write_paddr), 32'h04);
        check("lat_wdata", write_data, 32'hA5A5_0001);
        @(negedge pclk);
        check("lat_access_t3", 32'({transfer, penable, rsp_valid}), 32'(3'b110));
        pready = 1'b1;
        @(negedge pclk);
        pready = 1'b0;
        check("lat_rsp_t4", 32'({rsp_valid, rsp_err, transfer, penable}), 32'(4'b1000));
        check("lat_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        check("lat_rsp_drop", 32'(rsp_valid), 0);

        // UART read with 3 wait states, slave error, invalid select, timeout.
        push_cmd(mk(1'b0, 2'd2, 5'h01, 32'h0, 3, 1'b0, 3'b000, 32'h0000_0041));
        serve(mk(1'b0, 2'd2, 5'h01, 32'h0, 3, 1'b0, 3'b000, 32'h0000_0041));
        push_cmd(mk(1'b0, 2'd1, 5'h0A, 32'h0, 1, 1'b1, 3'b010, 32'hDEAD_BEEF));
        serve(mk(1'b0, 2'd1, 5'h0A, 32'h0, 1, 1'b1, 3'b010, 32'hDEAD_BEEF));
        push_cmd(mk(1'b1, 2'd0, 5'h03, 32'h1234_5678, 0, 1'b0, 3'b000, 32'h0));
        serve(mk(1'b1, 2'd0, 5'h03, 32'h1234_5678, 0, 1'b0, 3'b000, 32'h0));
        push_cmd(mk(1'b1, 2'd1, 5'h07, 32'h0BAD_F00D, T + 5, 1'b0, 3'b000, 32'h0));
        serve(mk(1'b1, 2'd1, 5'h07, 32'h0BAD_F00D, T + 5, 1'b0, 3'b000, 32'h0));

        // Backpressure: 6 offers with responses stalled, 5 accepted, returned in order.
        pready = 1'b1; echo_mode = 1'b1; acc = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_sel = (i % 2 == 1) ? 2'd2 : 2'd1;
            cmd_addr = 5'(i + 3); cmd_wdata = '0;
            if (cmd_ready) acc++;
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
        check("bp_accepted", 32'(acc), 5);
        check("bp_cmd_ready", 32'(cmd_ready), 0);
        for (int i = 0; i < 5; i++) begin
            seen = rsp_valid;
            for (int j = 0; j < 20 && !seen; j++) begin
                @(negedge pclk);
                seen = rsp_valid;
            end
            check("bp_rsp_seen", 32'(seen), 1);
            check("bp_rsp_order", rsp_rdata, 32'hEC00_0000 | 32'(i + 3));
            check("bp_rsp_err", 32'(rsp_err), 0);
            rsp_ready = 1'b1;
            @(negedge pclk);
            rsp_ready = 1'b0;
        end
        pready = 1'b0; echo_mode = 1'b0;
        repeat (3) @(negedge pclk);
        check("bp_drained", 32'({rsp_valid, transfer, cmd_ready}), 32'(3'b001));

        // Randomized batches against the transaction model.
        for (int b = 0; b < 12; b++) begin
            batch = {};
            k = int'($urandom_range(1, 6));
            for (int i = 0; i < k; i++) batch.push_back(rand_cmd());
            fork
                begin
                    for (int i = 0; i < k; i++) begin
                        repeat ($urandom_range(0, 2)) @(negedge pclk);
                        push_cmd(batch[i]);
                    end
                end
                begin
                    for (int i = 0; i < k; i++) serve(batch[i]);
                end
            join
        end

        // Reset during ACCESS with a second command queued.
        push_cmd(mk(1'b0, 2'd1, 5'h11, 32'h0, T + 5, 1'b0, 3'b000, 32'h0));
        push_cmd(mk(1'b1, 2'd2, 5'h12, 32'h5555_AAAA, 0, 1'b0, 3'b000, 32'h0));
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            seen = penable;
            if (!seen) @(negedge pclk);
        end
        check("rst_access_seen", 32'(seen), 1);
        repeat (2) @(negedge pclk);
        #2 PRESETn = 1'b0;
        #1;
        check("rst_async_bus", 32'({transfer, penable, Psel, rsp_valid}), 0);
        check("rst_async_ready", 32'(cmd_ready), 1);
        @(negedge pclk);
        PRESETn = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge pclk);
            if (rsp_valid || transfer) seen = 1;
        end
        check("rst_no_stale", 32'(seen), 0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule
